// File: rtl/seq_stage_ctrl.sv
// Stage sequencer for the sequential Y86-64 core: owns the PC, walks each instruction
// through six one-cycle stages and stops the machine on halt, bad opcode or address error.
module seq_stage_ctrl #(
   parameter logic [63:0] RESET_PC = 64'd0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [3:0]  iCode,
   input  logic        imem_error,
   input  logic        dmem_error,
   input  logic        cnd,
   input  logic [63:0] valP,
   input  logic [63:0] valC,
   input  logic [63:0] valM,
   output logic [63:0] PC,
   output logic        fetch_en,
   output logic        decode_en,
   output logic        exec_en,
   output logic        mem_en,
   output logic        wb_en,
   output logic [2:0]  stat,
   output logic        halted,
   output logic [63:0] instr_count
);

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_DECODE, S_EXECUTE, S_MEMORY, S_WRITEBACK, S_PCUPD, S_STOP
   } state_t;

   localparam logic [2:0] STAT_AOK = 3'd1;
   localparam logic [2:0] STAT_HLT = 3'd2;
   localparam logic [2:0] STAT_ADR = 3'd3;
   localparam logic [2:0] STAT_INS = 3'd4;

   localparam logic [3:0] IC_HALT = 4'h0;
   localparam logic [3:0] IC_JXX  = 4'h7;
   localparam logic [3:0] IC_CALL = 4'h8;
   localparam logic [3:0] IC_RET  = 4'h9;
   localparam logic [3:0] IC_MAX  = 4'hB;

   state_t      state_q, state_d;
   logic [63:0] pc_q, pc_d;
   logic [63:0] count_q, count_d;
   logic [2:0]  stat_q, stat_d;
   logic        cnd_q, cnd_d;
   logic [4:0]  stb_q, stb_d;
   logic [63:0] next_pc;

   always_comb begin
      unique case (iCode)
         IC_CALL: next_pc = valC;
         IC_JXX:  next_pc = cnd_q ? valC : valP;
         IC_RET:  next_pc = valM;
         default: next_pc = valP;
      endcase
   end

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      count_d = count_q;
      stat_d  = stat_q;
      cnd_d   = cnd_q;
      unique case (state_q)
         S_IDLE:    if (start) state_d = S_FETCH;
         S_FETCH: begin
            if (imem_error) begin
               stat_d  = STAT_ADR;
               state_d = S_STOP;
            end else if (iCode > IC_MAX) begin
               stat_d  = STAT_INS;
               state_d = S_STOP;
            end else if (iCode == IC_HALT) begin
               stat_d  = STAT_HLT;
               state_d = S_STOP;
            end else begin
               state_d = S_DECODE;
            end
         end
         S_DECODE:  state_d = S_EXECUTE;
         S_EXECUTE: begin
            cnd_d   = cnd;
            state_d = S_MEMORY;
         end
         S_MEMORY: begin
            if (dmem_error) begin
               stat_d  = STAT_ADR;
               state_d = S_STOP;
            end else begin
               state_d = S_WRITEBACK;
            end
         end
         S_WRITEBACK: state_d = S_PCUPD;
         S_PCUPD: begin
            pc_d    = next_pc;
            count_d = count_q + 64'd1;
            state_d = S_FETCH;
         end
         default:   state_d = S_STOP;
      endcase
   end

   // Strobes come straight from flops keyed on the next state, so they never glitch.
   always_comb begin
      stb_d = 5'b00000;
      unique case (state_d)
         S_FETCH:     stb_d = 5'b10000;
         S_DECODE:    stb_d = 5'b01000;
         S_EXECUTE:   stb_d = 5'b00100;
         S_MEMORY:    stb_d = 5'b00010;
         S_WRITEBACK: stb_d = 5'b00001;
         default:     stb_d = 5'b00000;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         pc_q    <= RESET_PC;
         count_q <= 64'd0;
         stat_q  <= STAT_AOK;
         cnd_q   <= 1'b0;
         stb_q   <= 5'b00000;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         count_q <= count_d;
         stat_q  <= stat_d;
         cnd_q   <= cnd_d;
         stb_q   <= stb_d;
      end
   end

   assign PC          = pc_q;
   assign instr_count = count_q;
   assign stat        = stat_q;
   assign halted      = (state_q == S_STOP);
   assign {fetch_en, decode_en, exec_en, mem_en, wb_en} = stb_q;

endmodule

// File: tb/tb_seq_stage_ctrl.sv
// Self-checking bench for seq_stage_ctrl: directed table of instructions, hand-written
// reset/stop sequences, and random programs checked against an instruction-level model.
module tb_seq_stage_ctrl;

   localparam logic [63:0] RESET_PC = 64'd0;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [3:0]  iCode = 4'h1;
   logic        imem_error = 1'b0;
   logic        dmem_error = 1'b0;
   logic        cnd = 1'b0;
   logic [63:0] valP = '0, valC = '0, valM = '0;
   logic [63:0] PC, instr_count;
   logic        fetch_en, decode_en, exec_en, mem_en, wb_en, halted;
   logic [2:0]  stat;

   seq_stage_ctrl #(.RESET_PC(RESET_PC)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .iCode(iCode),
      .imem_error(imem_error), .dmem_error(dmem_error), .cnd(cnd),
      .valP(valP), .valC(valC), .valM(valM), .PC(PC),
      .fetch_en(fetch_en), .decode_en(decode_en), .exec_en(exec_en),
      .mem_en(mem_en), .wb_en(wb_en), .stat(stat), .halted(halted),
      .instr_count(instr_count)
   );

   always #5 clk = ~clk;

   wire [4:0] stb = {fetch_en, decode_en, exec_en, mem_en, wb_en};

   int errors = 0;
   int checks = 0;

   // Architectural model: state of the machine between instructions.
   logic [63:0] m_pc, m_count;
   logic [2:0]  m_stat;
   bit          m_stop;

   typedef struct {
      bit          fresh;
      logic [3:0]  icode;
      bit          imem, dmem, c;
      logic [63:0] valp, valc, valm;
      logic [63:0] exp_pc, exp_count;
      logic [2:0]  exp_stat;
   } vec_t;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, " strobes"}, {59'd0, stb}, 64'd0);
      check({tag, " pc"}, PC, RESET_PC);
      check({tag, " count"}, instr_count, 64'd0);
      check({tag, " stat"}, {61'd0, stat}, 64'd1);
      check({tag, " halted"}, {63'd0, halted}, 64'd0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      start = 1'b0;
      #1;
      check_reset_values("reset");
      cycle();
      rst_n = 1'b1;
      m_pc = RESET_PC; m_count = 0; m_stat = 3'd1; m_stop = 0;
   endtask

   task automatic start_pulse();
      start = 1'b1;
      cycle();
      start = 1'b0;
   endtask

   // Drives one instruction from its FETCH cycle, checks every cycle and the retired result.
   task automatic run_instr(input vec_t v, input bit noise);
      bit          fetch_fault, ok;
      int          nsteps;
      logic [63:0] next;
      fetch_fault = v.imem || (v.icode > 4'd11) || (v.icode == 4'd0);
      nsteps = fetch_fault ? 1 : (v.dmem ? 4 : 6);
      iCode = v.icode; valP = v.valp; valC = v.valc; valM = v.valm;
      for (int k = 0; k < nsteps; k++) begin
         imem_error = (k == 0) ? v.imem : (noise ? 1'($urandom) : 1'b0);
         cnd        = (k == 2) ? v.c    : (noise ? 1'($urandom) : 1'b0);
         dmem_error = (k == 3) ? v.dmem : (noise ? 1'($urandom) : 1'b0);
         start      = noise ? 1'($urandom) : 1'b0;
         check($sformatf("strobe step%0d", k), {59'd0, stb}, (k < 5) ? (64'd16 >> k) : 64'd0);
         check($sformatf("pc step%0d", k), PC, m_pc);
         cycle();
      end
      start = 1'b0; imem_error = 1'b0; dmem_error = 1'b0;
      ok = 1;
      if (fetch_fault) begin
         m_stat = v.imem ? 3'd3 : ((v.icode > 4'd11) ? 3'd4 : 3'd2);
         m_stop = 1;
         ok = 0;
      end else if (v.dmem) begin
         m_stat = 3'd3;
         m_stop = 1;
         ok = 0;
      end
      if (ok) begin
         case (v.icode)
            4'd8:    next = v.valc;
            4'd7:    next = v.c ? v.valc : v.valp;
            4'd9:    next = v.valm;
            default: next = v.valp;
         endcase
         m_pc = next;
         m_count = m_count + 1;
      end
      check("post pc", PC, m_pc);
      check("post count", instr_count, m_count);
      check("post stat", {61'd0, stat}, {61'd0, m_stat});
      check("post halted", {63'd0, halted}, {63'd0, m_stop});
      if (!m_stop) check("next fetch_en", {59'd0, stb}, 64'd16);
      else         check("stop strobes", {59'd0, stb}, 64'd0);
   endtask

   // STOP must ignore start, held or pulsed, and keep everything frozen.
   task automatic stop_check();
      start = 1'b1;
      for (int k = 0; k < 4; k++) begin
         cycle();
         check("stop no strobe", {59'd0, stb}, 64'd0);
      end
      start = 1'b0;
      check("stop halted", {63'd0, halted}, 64'd1);
      check("stop pc", PC, m_pc);
      check("stop count", instr_count, m_count);
      check("stop stat", {61'd0, stat}, {61'd0, m_stat});
   endtask

   vec_t tbl[14];

   initial begin
      tbl[0]  = '{1, 4'h1, 0, 0, 0, 64'd1,    64'd0,     64'd0,   64'd1,     64'd1, 3'd1};
      tbl[1]  = '{0, 4'h1, 0, 0, 0, 64'd2,    64'd0,     64'd0,   64'd2,     64'd2, 3'd1};
      tbl[2]  = '{0, 4'h7, 0, 0, 1, 64'd9,    64'd64,    64'd0,   64'd64,    64'd3, 3'd1};
      tbl[3]  = '{0, 4'h7, 0, 0, 0, 64'd9,    64'd64,    64'd0,   64'd9,     64'd4, 3'd1};
      tbl[4]  = '{0, 4'h8, 0, 0, 1, 64'd18,   64'h100,   64'd0,   64'h100,   64'd5, 3'd1};
      tbl[5]  = '{0, 4'h9, 0, 0, 1, 64'h101,  64'h55,    64'h0A,  64'h0A,    64'd6, 3'd1};
      tbl[6]  = '{1, 4'h1, 0, 0, 0, 64'h40,   64'd0,     64'd0,   64'h40,    64'd1, 3'd1};
      tbl[7]  = '{0, 4'h0, 0, 0, 0, 64'h41,   64'd0,     64'd0,   64'h40,    64'd1, 3'd2};
      tbl[8]  = '{1, 4'h1, 0, 0, 0, 64'h40,   64'd0,     64'd0,   64'h40,    64'd1, 3'd1};
      tbl[9]  = '{0, 4'hC, 0, 0, 0, 64'h41,   64'd0,     64'd0,   64'h40,    64'd1, 3'd4};
      tbl[10] = '{1, 4'h1, 0, 0, 0, 64'h40,   64'd0,     64'd0,   64'h40,    64'd1, 3'd1};
      tbl[11] = '{0, 4'h1, 1, 0, 0, 64'h41,   64'd0,     64'd0,   64'h40,    64'd1, 3'd3};
      tbl[12] = '{1, 4'h1, 0, 0, 0, 64'h40,   64'd0,     64'd0,   64'h40,    64'd1, 3'd1};
      tbl[13] = '{0, 4'h5, 0, 1, 0, 64'h4A,   64'd0,     64'd0,   64'h40,    64'd1, 3'd3};

      m_pc = RESET_PC; m_count = 0; m_stat = 3'd1; m_stop = 0;
      @(negedge clk);
      #1;
      check_reset_values("power-on");
      @(negedge clk);

      // Directed table.
      for (int i = 0; i < 14; i++) begin
         if (tbl[i].fresh) begin
            do_reset();
            start_pulse();
         end
         run_instr(tbl[i], 0);
         check($sformatf("tbl%0d pc", i), PC, tbl[i].exp_pc);
         check($sformatf("tbl%0d count", i), instr_count, tbl[i].exp_count);
         check($sformatf("tbl%0d stat", i), {61'd0, stat}, {61'd0, tbl[i].exp_stat});
         if (tbl[i].exp_stat != 3'd1) stop_check();
      end

      // Reset asserted during EXECUTE abandons the instruction.
      do_reset();
      start_pulse();
      run_instr('{1, 4'h1, 0, 0, 0, 64'h40, 64'd0, 64'd0, 64'h40, 64'd1, 3'd1}, 0);
      iCode = 4'h8; valC = 64'h200; valP = 64'h4A;
      cycle();
      cycle();
      check("mid exec_en", {59'd0, stb}, 64'd4);
      do_reset();
      check("idle no fetch", {59'd0, stb}, 64'd0);
      start_pulse();
      check("restart fetch_en", {59'd0, stb}, 64'd16);
      check("restart pc", PC, RESET_PC);
      run_instr('{0, 4'h8, 0, 0, 0, 64'h9, 64'h200, 64'd0, 64'h200, 64'd1, 3'd1}, 0);

      // Random programs with noise on don't-care cycles.
      do_reset();
      start_pulse();
      for (int n = 0; n < 400; n++) begin
         vec_t v;
         int   r;
         if (m_stop) begin
            stop_check();
            do_reset();
            start_pulse();
         end
         r = int'($urandom_range(0, 99));
         v.fresh = 0;
         v.imem  = (r < 3);
         if (r >= 3 && r < 6) v.icode = (r == 3) ? 4'h0 : 4'(12 + $urandom_range(0, 3));
         else                 v.icode = 4'($urandom_range(1, 11));
         v.dmem  = ($urandom_range(0, 99) < 4);
         v.c     = 1'($urandom);
         v.valp  = {$urandom, $urandom};
         v.valc  = {$urandom, $urandom};
         v.valm  = {$urandom, $urandom};
         v.exp_pc = '0; v.exp_count = '0; v.exp_stat = '0;
         run_instr(v, 1);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/seq_stage_ctrl.md
# seq_stage_ctrl

Stage sequencer for the sequential Y86-64 core. It owns the program counter and steps one instruction at a time through fetch, decode, execute, memory, write-back and PC-update. Each stage gets a one-cycle enable strobe. The block selects the next PC, tracks the Y86 status code and stops the machine on halt, invalid instruction or address error. It sits above the fetch, decode, execute, memory and write-back blocks and replaces hand-driven PC/clock sequencing.

## Interface
- RESET_PC, 64'd0, PC loaded on reset.
- clk  in  1  core clock; all state changes on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  begin execution from PC; sampled only in IDLE.
- iCode  in  4  instruction code from fetch; valid while fetch_en is high and afterwards.
- imem_error  in  1  fetch address error; sampled in FETCH.
- dmem_error  in  1  data memory address error; sampled in MEMORY.
- cnd  in  1  condition result from execute; sampled in EXECUTE.
- valP  in  64  fall-through address from fetch.
- valC  in  64  constant word from fetch.
- valM  in  64  word read by memory (return address for ret).
- PC  out  64  current instruction address.
- fetch_en, decode_en, exec_en, mem_en, wb_en  out  1 each  one-hot stage strobes.
- stat  out  3  1=AOK, 2=HLT, 3=ADR, 4=INS.
- halted  out  1  high in STOP.
- instr_count  out  64  retired instructions.

## Operation
- States: IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, PCUPD, STOP.
- Strobe per state: fetch_en in FETCH, decode_en in DECODE, exec_en in EXECUTE, mem_en in MEMORY, wb_en in WRITEBACK.
  - At most one strobe is high in any cycle.
  - No strobe is high in IDLE, PCUPD or STOP.
- IDLE -> FETCH when start=1. Otherwise the block stays in IDLE.
- FETCH exits are checked in priority order:
  - imem_error=1 -> stat=ADR, go to STOP.
  - iCode>4'hB -> stat=INS, go to STOP.
  - iCode=0 (halt) -> stat=HLT, go to STOP.
  - Otherwise -> DECODE.
- DECODE -> EXECUTE -> MEMORY, unconditionally.
- EXECUTE latches cnd into an internal register, cnd_q.
- MEMORY:
  - dmem_error=1 -> stat=ADR, go to STOP. WRITEBACK is skipped and instr_count does not change.
  - Otherwise -> WRITEBACK -> PCUPD.
- Every valid instruction walks all stages, including MEMORY. Each instruction takes exactly 6 cycles.
- PCUPD -> FETCH. On the PCUPD edge:
  - PC is loaded with the next PC.
  - instr_count increments by 1.
- Next-PC selection:
  - iCode=8 (call) -> valC.
  - iCode=7 (jXX) and cnd_q=1 -> valC.
  - iCode=9 (ret) -> valM.
  - Otherwise -> valP.
- On every STOP entry, PC keeps the address of the faulting or halting instruction.
- STOP is terminal: start is ignored and only rst_n leaves STOP.
- PC arithmetic is 64-bit with no bounds check; valP/valC/valM are taken verbatim, so wrap-around is the source's concern.
- instr_count wraps modulo 2^64.

## Timing
- Reset values (asynchronous, while rst_n=0):
  - state=IDLE, PC=RESET_PC, stat=AOK(1), halted=0, instr_count=0, cnd_q=0, all strobes 0.
- If rst_n is asserted mid-instruction, the instruction is abandoned immediately; no partial PC or counter update.
- start sampled high in IDLE at edge t -> fetch_en high during cycle t+1.
- Strobes are registered state decodes, so they are glitch-free. A stage sees its inputs stable for the whole strobe cycle.
- Instruction n's fetch_en to instruction n+1's fetch_en is 6 cycles.
- stat and halted update on the same edge that enters STOP and then hold.
- Inputs matter only in the state that samples them; they are don't-care elsewhere.
- start held high continuously: only the IDLE sample counts.

## Test plan
- Two nops (iCode=1) at PC=0, valP=1 then 2, start pulse:
  - fetch_en at cycles 1 and 7.
  - PC=1 after cycle 6, PC=2 after cycle 12.
  - instr_count=2, stat=1.
- jXX (iCode=7) with valC=64'd64, valP=9:
  - cnd=1 -> PC=64.
  - cnd=0 -> PC=9.
- call (iCode=8, valC=0x100) -> PC=0x100. Then ret (iCode=9, valM=0x0A) -> PC=0x0A.
- Fetch faults, each starting at PC=0x40:
  - halt (iCode=0) -> stat=2, halted=1, PC stays 0x40, no decode_en, instr_count unchanged.
  - iCode=4'hC -> stat=4.
  - imem_error -> stat=3.
  - In all three cases, a later start does nothing.
- mrmovq (iCode=5) with dmem_error=1 in MEMORY -> stat=3, no wb_en, PC unchanged.
- rst_n low during EXECUTE -> outputs return to reset values at once. A new start begins fetch from RESET_PC.
